// File: rtl/debug_step_sequencer_pkg.sv
// Shared selector codes, FSM state encoding and argument decode for the
// debug step sequencer.
package debug_step_sequencer_pkg;

  localparam logic [5:0] SEL_CLK_LO = 6'h38;
  localparam logic [5:0] SEL_STEP   = 6'h3F;
  localparam logic [5:0] SEL_MULTI  = 6'h3E;

  localparam logic [7:0] CODE_CLK_LO = {2'b00, SEL_CLK_LO};
  localparam logic [7:0] CODE_CLK_HI = {2'b00, SEL_STEP};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_ARG,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_READ,
    ST_SEND
  } state_t;

  // A multi-step argument of zero requests the full 256 pulses.
  function automatic logic [8:0] step_total(input logic [7:0] arg);
    return (arg == 8'h00) ? 9'd256 : {1'b0, arg};
  endfunction

endpackage

// File: rtl/debug_step_sequencer_if.sv
// Byte-link and debug-decoder signals seen by the step sequencer.
interface debug_step_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_code;
  logic [31:0] dbg_result;
  logic [1:0]  dbg_size;

  modport master (
    output rx_data, rx_valid, tx_ready, dbg_result, dbg_size,
    input  tx_data, tx_valid, dbg_code
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, dbg_result, dbg_size,
    output tx_data, tx_valid, dbg_code
  );
endinterface

// File: rtl/debug_step_sequencer_tx_shifter.sv
// LSB-first byte shifter for 1-4 byte responses with a valid/ready handshake;
// o_done flags the edge on which the final byte is accepted.
module debug_tx_shifter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_nbytes;
  logic        r_valid;
  logic        w_accept;

  assign w_accept = r_valid && i_ready;
  assign o_done   = w_accept && (r_nbytes == 3'd1);
  assign o_data   = r_shift[7:0];
  assign o_valid  = r_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_shift  <= 32'd0;
      r_nbytes <= 3'd0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_data;
      r_nbytes <= i_nbytes;
      r_valid  <= 1'b1;
    end else if (w_accept) begin
      r_shift  <= {8'h00, r_shift[31:8]};
      r_nbytes <= r_nbytes - 3'd1;
      if (r_nbytes == 3'd1) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_step_sequencer.sv
// Command sequencer between the UART byte link and the MIPS debug decoder:
// single/multi-steps the pipeline clock and returns probe values as bytes.
//
// state       | meaning
// IDLE        | pipeline clock low, waiting for a command byte
// DISPATCH    | decode the latched command
// ARG         | waiting for the multi-step count byte
// CLK_LO      | pipeline clock low phase (also the trailing low after the last pulse)
// CLK_HI      | pipeline clock high phase
// READ        | selector driven, waiting for the decoder result to settle
// SEND        | response bytes going out through the shifter
module debug_step_sequencer
  import debug_step_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  ACK_BYTE      = 8'hA5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  debug_step_sequencer_if.slave  bus,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic [15:0]            o_step_count
);

  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cmd;
  logic [7:0]  r_dbg_code;
  logic [15:0] r_cnt;
  logic [8:0]  r_n;
  logic [15:0] r_step_count;
  logic        r_overrun;

  logic        w_cnt_zero;
  logic        w_load;
  logic [31:0] w_load_data;
  logic [2:0]  w_load_nbytes;
  logic        w_tx_done;

  assign w_cnt_zero   = (r_cnt == 16'd0);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_overrun    = r_overrun;
  assign o_step_count = r_step_count;
  assign bus.dbg_code = r_dbg_code;

  // Shifter load coincides with the FSM edge that enters SEND.
  always_comb begin
    w_load        = 1'b0;
    w_load_data   = {24'd0, ACK_BYTE};
    w_load_nbytes = 3'd1;
    case (r_state)
      ST_DISPATCH: w_load = (r_cmd[5:0] == SEL_CLK_LO);
      ST_CLK_LO:   w_load = w_cnt_zero && (r_n == 9'd0);
      ST_READ: begin
        w_load        = w_cnt_zero;
        w_load_data   = bus.dbg_result;
        w_load_nbytes = {1'b0, bus.dbg_size} + 3'd1;
      end
      default:     w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_cmd        <= 8'd0;
      r_dbg_code   <= CODE_CLK_LO;
      r_cnt        <= 16'd0;
      r_n          <= 9'd0;
      r_step_count <= 16'd0;
      r_overrun    <= 1'b0;
    end else begin
      if (bus.rx_valid && (r_state != ST_IDLE) && (r_state != ST_ARG))
        r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_dbg_code <= CODE_CLK_LO;
          if (bus.rx_valid) begin
            r_cmd   <= bus.rx_data;
            r_state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (r_cmd[5:0] == SEL_STEP) begin
            r_n     <= 9'd1;
            r_cnt   <= HOLD_LOAD;
            r_state <= ST_CLK_LO;
          end else if (r_cmd[5:0] == SEL_MULTI) begin
            r_state <= ST_ARG;
          end else if (r_cmd[5:0] == SEL_CLK_LO) begin
            r_state <= ST_SEND;
          end else begin
            r_dbg_code <= r_cmd;
            r_cnt      <= SETTLE_LOAD;
            r_state    <= ST_READ;
          end
        end
        ST_ARG: begin
          if (bus.rx_valid) begin
            r_n     <= step_total(bus.rx_data);
            r_cnt   <= HOLD_LOAD;
            r_state <= ST_CLK_LO;
          end
        end
        // r_n reaching zero here means the trailing low phase just finished.
        ST_CLK_LO: begin
          r_dbg_code <= CODE_CLK_LO;
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (r_n == 9'd0) begin
            r_state <= ST_SEND;
          end else begin
            r_dbg_code <= CODE_CLK_HI;
            r_cnt      <= HOLD_LOAD;
            r_state    <= ST_CLK_HI;
          end
        end
        ST_CLK_HI: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_dbg_code   <= CODE_CLK_LO;
            r_step_count <= r_step_count + 16'd1;
            r_n          <= r_n - 9'd1;
            r_cnt        <= HOLD_LOAD;
            r_state      <= ST_CLK_LO;
          end
        end
        ST_READ: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_dbg_code <= CODE_CLK_LO;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_dbg_code <= CODE_CLK_LO;
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  debug_tx_shifter u_tx_shifter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_nbytes (w_load_nbytes),
    .i_ready  (bus.tx_ready),
    .o_data   (bus.tx_data),
    .o_valid  (bus.tx_valid),
    .o_done   (w_tx_done)
  );

endmodule
